// File: rtl/sw_pkg.sv
// Shared constants for the slide-switch conditioning stage.
// Board timing (100 MHz clock, 10 ms debounce window) and the short window
// used when simulating, so benches do not have to run a million cycles.
package sw_pkg;

  localparam int NUM_SW                  = 16;
  localparam int CLK_HZ                  = 100_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit switch conditioner: 2-flop synchroniser, stability counter,
// debounced state flop and registered rise/fall pulses.
// Ports: clk, rst_n (async active-low), sw_raw_i (async pin),
//        sw_db_o / sw_rise_o / sw_fall_o (registered),
//        flip_o (next-cycle flip indication, lets the parent register an
//        aggregate pulse aligned with rise/fall; driven from flops only).
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw_i,
  output logic sw_db_o,
  output logic sw_rise_o,
  output logic sw_fall_o,
  output logic flip_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;
  logic             flip;

  // Counter only advances while the synchronised input disagrees with the
  // debounced state; any agreeing cycle discards the partial count. Reaching
  // CNT_MAX while still disagreeing is the flip point, so the counter never
  // needs to go past CNT_MAX.
  always_comb begin
    cnt_d = '0;
    flip  = 1'b0;
    if (sync_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        flip = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    db_d   = db_q ^ flip;
    rise_d = flip & ~db_q;
    fall_d = flip & db_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= sw_raw_i;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sw_db_o   = db_q;
  assign sw_rise_o = rise_q;
  assign sw_fall_o = fall_q;
  assign flip_o    = flip;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: per-bit synchronise + debounce, per-bit edge
// pulses and a single aggregate change pulse, all registered.
// Ports: clk, rst_n (async active-low), sw_raw[WIDTH] (async pins),
//        sw_db / sw_rise / sw_fall [WIDTH], sw_changed.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH           = NUM_SW,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] flip;
  logic             changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_raw_i  (sw_raw[i]),
      .sw_db_o   (sw_db[i]),
      .sw_rise_o (sw_rise[i]),
      .sw_fall_o (sw_fall[i]),
      .flip_o    (flip[i])
    );
  end

  // Registered from the bits' next-cycle flip so the pulse lands in the same
  // cycle as the rise/fall flops rather than one cycle after them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |flip;
    end
  end

  assign sw_changed = changed_q;

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Upstream conditioning stage for the 16 slide switches on the Basys3 board. It sits between the raw switch pins and the switch-to-LED display logic. It synchronises each asynchronous switch input into the clk domain and debounces each bit independently. It also produces per-bit one-cycle edge pulses and an aggregate change pulse for downstream consumers. The sw_db output drives the LED display stage directly.

Parameters:
WIDTH, 16, number of switch bits handled.
DEBOUNCE_CYCLES, 1000000, clk cycles a synchronised input must differ from sw_db before sw_db follows it (10 ms at 100 MHz); legal range is 2 or more.
CNT_W, $clog2(DEBOUNCE_CYCLES), width of the per-bit stability counter (derived; not overridden).

Ports:
clk  input  1  system clock, 100 MHz on board
rst_n  input  1  asynchronous active-low reset
sw_raw  input  WIDTH  raw switch pins, asynchronous to clk
sw_db  output  WIDTH  debounced switch state, registered
sw_rise  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 0->1
sw_fall  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 1->0
sw_changed  output  1  one-cycle pulse when any sw_rise or sw_fall bit is set in the same cycle

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. On assertion, immediately clear the sync flops, counters, sw_db, sw_rise, sw_fall and sw_changed to 0. Release is synchronous to clk through the flop clear.
- Synchroniser: two flops per bit (meta, sync) feed the counter logic. sw_raw is never used directly.
- Per-bit counter, evaluated every clk edge:
  - If sync == sw_db: cnt <= 0.
  - If sync != sw_db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If sync != sw_db and cnt == DEBOUNCE_CYCLES-1: sw_db <= sync, cnt <= 0, and the matching edge pulse is set for that one cycle.
- Latency: let edge 1 be the first edge that samples a new, stable sw_raw value. Then sync holds it after edge 2, the mismatch is counted on edges 3 .. DEBOUNCE_CYCLES+2, and sw_db flips on edge DEBOUNCE_CYCLES+2. Total latency is exactly DEBOUNCE_CYCLES+2 cycles.
- Glitch rejection: a mismatch at sync lasting fewer than DEBOUNCE_CYCLES cycles never changes sw_db. The counter returns to 0 on the first matching cycle; partial counts are not held.
- Edge pulses:
  - sw_rise[i] and sw_fall[i] are registered and assert in the same cycle sw_db[i] changes, for exactly one cycle. They are never both high.
  - sw_changed is the OR of all rise and fall bits, aligned in the same cycle.
- Simultaneous events: bits are fully independent. Several bits flipping on the same edge give several rise/fall bits set in one cycle, and sw_changed pulses once.
- Continuous bouncing: sw_db holds its value indefinitely with no pulses.
- Counter never wraps: it saturates by design at DEBOUNCE_CYCLES-1 and clears on flip.
- Reset mid-count: partial counts are discarded. After release, a switch already high gives sw_rise exactly DEBOUNCE_CYCLES+2 edges after the first sampling edge. This is the required power-up behaviour.
- No combinational path from sw_raw to any output.

Decomposition:
- Package sw_pkg:
  - NUM_SW = 16
  - CLK_HZ = 100000000
  - DEBOUNCE_MS = 10
  - DEBOUNCE_CYCLES_DEFAULT = CLK_HZ/1000*DEBOUNCE_MS
  - SIM_DEBOUNCE_CYCLES = 4, for benches
- Sub-module sw_debounce_bit: one bit's two-flop synchroniser, counter, db flop and rise/fall flops.
- The top generates WIDTH instances and registers the sw_changed reduction.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold rst_n=0 with sw_raw=16'hFFFF -> all outputs 0. Release -> sw_db=16'hFFFF on edge 6; sw_rise=16'hFFFF and sw_changed=1 for that single cycle.
- Clean step: sw_raw 16'h0000->16'h0001 held -> sw_db[0]=1 exactly 6 edges after the first sampling edge; one-cycle sw_rise=16'h0001. Then 1->0 -> one-cycle sw_fall=16'h0001 after 6 edges.
- Glitch: sw_raw[3] high for 3 cycles then low, repeated 5 times -> sw_db stays 16'h0000; no rise, fall or changed pulse at any point.
- Simultaneous: sw_raw 16'h00F0->16'h0F00 in one step -> on the same edge sw_db=16'h0F00, sw_rise=16'h0F00, sw_fall=16'h00F0, and sw_changed pulses once.
- Reset mid-count: step sw_raw[15] to 1, assert rst_n after 3 edges, release -> no pulse before release. sw_db=16'h8000 only 6 edges after the first post-release sampling edge.
